// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and constants for the mux_arb4 operand-mux
// arbiter.
//   state_t      : arbiter FSM states (IDLE, OWN)
//   SEL_A..SEL_D : OP encodings driven onto the 4:1 operand mux select
//   WIDTH_DEF    : default data width
//   MAX_HOLD_DEF : default burst limit while other requesters are waiting
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    localparam int WIDTH_DEF    = 16;
    localparam int MAX_HOLD_DEF = 4;

endpackage

// File: rtl/mux_arb4_if.sv
// mux_arb4_if: bus between the four requesters and the operand mux on one
// side and the arbiter on the other.
//   Req       : level requests, bit k selects mux input A/B/C/D
//   MuxOut    : combinational mux output, selected by OP
//   OP        : mux select (registered with Grant)
//   Grant     : one-hot owner, 0000 when idle
//   Busy      : any grant active
//   Data      : registered MuxOut captured during a valid grant
//   DataValid : Data was captured at the most recent edge
// modport slave  : arbiter side
// modport master : requesters and mux side
interface mux_arb4_if #(
    parameter int WIDTH = mux_arb_pkg::WIDTH_DEF
);
    logic [3:0]       Req;
    logic [WIDTH-1:0] MuxOut;
    logic [1:0]       OP;
    logic [3:0]       Grant;
    logic             Busy;
    logic [WIDTH-1:0] Data;
    logic             DataValid;

    modport slave (
        input  Req,
        input  MuxOut,
        output OP,
        output Grant,
        output Busy,
        output Data,
        output DataValid
    );

    modport master (
        output Req,
        output MuxOut,
        input  OP,
        input  Grant,
        input  Busy,
        input  Data,
        input  DataValid
    );
endinterface

// File: rtl/mux_arb4_rr_pick4.sv
// rr_pick4: combinational 4-way rotating picker.
//   req   : request vector
//   start : index searched first; the search goes upward with wrap
//   valid : any req bit set
//   idx   : first set index found from start
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       valid,
    output logic [1:0] idx
);
    logic [7:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;

    // Rotate so that bit 0 of w_rot is req[start]; then a plain
    // priority encode gives the offset from start.
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[start +: 4];

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
    end

    assign valid = |req;
    assign idx   = start + w_off;
endmodule

// File: rtl/mux_arb4.sv
// mux_arb4: round-robin arbiter / sequencer for the shared 4:1 operand mux.
// Grants one of four requesters for a bounded burst, drives the mux select,
// and registers the selected mux output with a valid strobe.
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset
//   bus   : mux_arb4_if.slave (Req, MuxOut in; OP, Grant, Busy, Data,
//           DataValid out)
// Parameters: WIDTH (data width), MAX_HOLD (1..15, burst limit while
// others wait).
// Build option: define MUX_ARB_FIXED_PRIO_EN for fixed priority A>B>C>D
// (preemption at MAX_HOLD only to a strictly higher-priority requester).
module mux_arb4
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    mux_arb4_if.slave   bus
);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t           r_state;
    logic [3:0]       r_grant;
    logic [1:0]       r_op;
    logic [3:0]       r_hold;
    logic [WIDTH-1:0] r_data;
    logic             r_dv;

    state_t           w_state_nxt;
    logic [3:0]       w_grant_nxt;
    logic [1:0]       w_op_nxt;
    logic [3:0]       w_hold_nxt;
    logic             w_take;
    logic             w_own_req;
    logic [3:0]       w_pick_req;
    logic             w_pick_vld;
    logic [1:0]       w_pick_idx;
    logic [1:0]       w_start;
    logic             w_preempt;

    // Owner's bit is masked out so the picker only sees challengers; when
    // the owner has dropped its bit is already zero.
    assign w_own_req  = |(bus.Req & r_grant);
    assign w_pick_req = bus.Req & ~r_grant;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign w_start   = SEL_A;
    assign w_preempt = w_pick_vld && (r_hold == HOLD_MAX) && (w_pick_idx < r_op);
`else
    logic [1:0] r_last;

    assign w_start   = r_last + 2'd1;
    assign w_preempt = w_pick_vld && (r_hold == HOLD_MAX);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      r_last <= SEL_D;
        else if (w_take) r_last <= w_pick_idx;
    end
`endif

    rr_pick4 u_pick (
        .req   (w_pick_req),
        .start (w_start),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    // State register (with grant/select/hold and capture path).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_op    <= SEL_A;
            r_hold  <= 4'd0;
            r_data  <= '0;
            r_dv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_op    <= w_op_nxt;
            r_hold  <= w_hold_nxt;
            // Capture uses the pre-edge owner, so a handover edge still
            // records the outgoing owner's operand.
            if (w_own_req) begin
                r_data <= bus.MuxOut;
                r_dv   <= 1'b1;
            end else begin
                r_dv   <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_op_nxt    = r_op;
        w_hold_nxt  = r_hold;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) w_take = 1'b1;
            end
            OWN: begin
                if (w_own_req) begin
                    if (w_preempt)
                        w_take = 1'b1;
                    else if (r_hold < HOLD_MAX)
                        w_hold_nxt = r_hold + 4'd1;
                end else if (w_pick_vld) begin
                    w_take = 1'b1;
                end else begin
                    // OP deliberately keeps its last value when idle.
                    w_state_nxt = IDLE;
                    w_grant_nxt = 4'b0000;
                    w_hold_nxt  = 4'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 4'b0000;
                w_hold_nxt  = 4'd0;
            end
        endcase
        if (w_take) begin
            w_state_nxt = OWN;
            w_grant_nxt = 4'b0001 << w_pick_idx;
            w_op_nxt    = w_pick_idx;
            w_hold_nxt  = 4'd1;
        end
    end

    // Outputs, all straight from registers.
    always_comb begin
        bus.OP        = r_op;
        bus.Grant     = r_grant;
        bus.Busy      = (r_state == OWN);
        bus.Data      = r_data;
        bus.DataValid = r_dv;
    end
endmodule

// File: tb/tb_mux_arb4.sv
module tb_mux_arb4;
    logic CLK;
    logic RST_N;
    int   total = 0;
    int   bad   = 0;

    mux_arb4_if #(.WIDTH(16)) bus ();

    mux_arb4 #(.WIDTH(16), .MAX_HOLD(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Operand mux model: A=8, B=4, C=2, D=1.
    always_comb begin
        case (bus.OP)
            2'd0:    bus.MuxOut = 16'h0008;
            2'd1:    bus.MuxOut = 16'h0004;
            2'd2:    bus.MuxOut = 16'h0002;
            default: bus.MuxOut = 16'h0001;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] vals [4];
        logic [3:0]  oh;
        int          own;
        vals[0] = 16'h0008; vals[1] = 16'h0004;
        vals[2] = 16'h0002; vals[3] = 16'h0001;

        // Async reset before any clock edge.
        RST_N   = 1'b1;
        bus.Req = 4'b1111;
        #1 RST_N = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.Grant), 32'h0);
        chk("rst_op", 32'(bus.OP), 32'h0);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        chk("rst_data", 32'(bus.Data), 32'h0);
        chk("rst_dv", 32'(bus.DataValid), 32'h0);
        #1 RST_N = 1'b1;
        tick();
        chk("first_grant", 32'(bus.Grant), 32'b0001);
        chk("first_busy", 32'(bus.Busy), 32'h1);
        chk("first_dv", 32'(bus.DataValid), 32'h0);
        bus.Req = 4'b0000;
        tick();
        chk("idle_grant", 32'(bus.Grant), 32'h0);
        chk("idle_busy", 32'(bus.Busy), 32'h0);

        // Single requester C.
        bus.Req = 4'b0100;
        tick();
        chk("c_grant", 32'(bus.Grant), 32'b0100);
        chk("c_op", 32'(bus.OP), 32'd2);
        chk("c_dv0", 32'(bus.DataValid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c_dv", 32'(bus.DataValid), 32'h1);
            chk("c_data", 32'(bus.Data), 32'h0002);
        end
        bus.Req = 4'b0000;
        tick();
        chk("c_rel_grant", 32'(bus.Grant), 32'h0);
        chk("c_rel_dv", 32'(bus.DataValid), 32'h0);
        chk("c_rel_op", 32'(bus.OP), 32'd2);
        tick();
        chk("c_rel_dv2", 32'(bus.DataValid), 32'h0);

        // Full rotation from a fresh reset.
        RST_N = 1'b0;
        #1 RST_N = 1'b1;
        bus.Req = 4'b1111;
        for (int n = 1; n <= 17; n++) begin
            tick();
            own = ((n - 1) / 4) % 4;
            oh  = 4'b0001 << own;
            chk("rr_grant", 32'(bus.Grant), 32'(oh));
            chk("rr_op", 32'(bus.OP), 32'(own));
            if (n >= 2) begin
                chk("rr_dv", 32'(bus.DataValid), 32'h1);
                chk("rr_data", 32'(bus.Data), 32'(vals[((n - 2) / 4) % 4]));
            end
        end

        // Reset while owning aborts immediately; restart at requester 0.
        #2 RST_N = 1'b0;
        #1;
        chk("rst_own_grant", 32'(bus.Grant), 32'h0);
        chk("rst_own_busy", 32'(bus.Busy), 32'h0);
        chk("rst_own_dv", 32'(bus.DataValid), 32'h0);
        chk("rst_own_data", 32'(bus.Data), 32'h0);
        #1 RST_N = 1'b1;
        tick();
        chk("rst_own_regrant", 32'(bus.Grant), 32'b0001);

        // Lone owner keeps the grant; late challenger wins at once.
        bus.Req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("solo_grant", 32'(bus.Grant), 32'b0001);
        end
        bus.Req = 4'b1001;
        tick();
        chk("late_grant", 32'(bus.Grant), 32'b1000);
        chk("late_op", 32'(bus.OP), 32'd3);
        chk("late_data", 32'(bus.Data), 32'h0008);

        // Owner drop with pending challenger: no idle bubble.
        bus.Req = 4'b0001;
        tick();
        chk("back_a_grant", 32'(bus.Grant), 32'b0001);
        chk("back_a_dv", 32'(bus.DataValid), 32'h0);
        tick();
        chk("a_dv", 32'(bus.DataValid), 32'h1);
        chk("a_data", 32'(bus.Data), 32'h0008);
        bus.Req = 4'b0010;
        tick();
        chk("ho_grant", 32'(bus.Grant), 32'b0010);
        chk("ho_busy", 32'(bus.Busy), 32'h1);
        chk("ho_dv", 32'(bus.DataValid), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("b_dv", 32'(bus.DataValid), 32'h1);
            chk("b_data", 32'(bus.Data), 32'h0004);
        end
        bus.Req = 4'b0000;
        tick();
        chk("end_grant", 32'(bus.Grant), 32'h0);
        tick();
        chk("end_dv", 32'(bus.DataValid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
